// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port memory arbiter/sequencer.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN, DONE} state_t;

  localparam logic [1:0] ACCESS_1W  = 2'b00;
  localparam logic [1:0] ACCESS_4W  = 2'b01;
  localparam logic [1:0] ACCESS_8W  = 2'b10;
  localparam logic [1:0] ACCESS_16W = 2'b11;

  function automatic logic [4:0] size_to_beats(input logic [1:0] size);
    case (size)
      ACCESS_1W: return 5'd1;
      ACCESS_4W: return 5'd4;
      ACCESS_8W: return 5'd8;
      default:   return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick; last_grant resets to 1 so port 0 wins the first tie.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic       pick,
  output logic       any
);

  logic last_grant;

  always_comb begin
    pick = 1'b0;
    case (valid)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      default: pick = ~last_grant;
    endcase
  end

  assign any = |valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    last_grant <= 1'b1;
    else if (accept) last_grant <= pick;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Burst arbiter/sequencer splitting granted bursts into single-word accesses.
// Optional range check on accepted requests: define MEM_ARB_ADDR_CHECK_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                 ADDR_W       = 32,
  parameter int                 DATA_W       = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR    = 32'h80020000,
  parameter int unsigned        DEPTH        = 1048576,
  parameter int                 READ_LATENCY = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [1:0]          req_rw,
  input  logic [3:0]          req_size,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          wdata_ack,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rdata_valid,
  output logic [1:0]          done,
  output logic [1:0]          err,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_data_in,
  output logic [1:0]          mem_access_size,
  output logic                mem_rw,
  output logic                mem_enable,
  input  logic [DATA_W-1:0]   mem_data_out
);

`ifdef MEM_ARB_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif
  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_t                  state;
  logic                    g;
  logic [ADDR_W-1:0]       base;
  logic                    rw;
  logic [4:0]              beats;
  logic [4:0]              beat;
  logic [LAT_W-1:0]        drain_cnt;
  logic [READ_LATENCY-1:0] rd_pipe;
  logic [DATA_W-1:0]       wdata_hold;
  logic [DATA_W-1:0]       rdata_hold;
  logic                    err_flag;

  logic                    pick;
  logic                    any;
  logic                    handshake;
  logic [ADDR_W-1:0]       sel_addr;
  logic [ADDR_W-1:0]       sel_base;
  logic [1:0]              sel_size;
  logic [4:0]              sel_beats;
  logic                    sel_rw;
  logic [ADDR_W:0]         burst_end;
  logic                    in_window;
  logic                    reject;
  logic                    write_beat;
  logic [DATA_W-1:0]       cur_wdata;

  rr_arbiter2 u_rr (
    .clock   (clock),
    .reset_n (reset_n),
    .valid   (req_valid),
    .accept  (handshake),
    .pick    (pick),
    .any     (any)
  );

  assign handshake = (state == IDLE) && any;
  assign req_ready = handshake ? (2'b01 << pick) : 2'b00;

  assign sel_addr  = pick ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign sel_base  = sel_addr & ~ADDR_W'(3);
  assign sel_size  = pick ? req_size[3:2] : req_size[1:0];
  assign sel_rw    = req_rw[pick];
  assign sel_beats = size_to_beats(sel_size);

  // Range check is done one bit wider so a burst ending past the top of the address space is caught.
  assign burst_end = {1'b0, sel_base} + (ADDR_W+1)'({sel_beats, 2'b00});
  assign in_window = ({1'b0, sel_base} >= (ADDR_W+1)'(BASE_ADDR)) &&
                     (burst_end <= (ADDR_W+1)'(BASE_ADDR) + (ADDR_W+1)'(DEPTH));
  assign reject    = ADDR_CHECK && !in_window;

  assign write_beat = (state == BURST) && !rw;
  assign cur_wdata  = g ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      g          <= 1'b0;
      base       <= '0;
      rw         <= 1'b0;
      beats      <= '0;
      beat       <= '0;
      drain_cnt  <= '0;
      rd_pipe    <= '0;
      wdata_hold <= '0;
      rdata_hold <= '0;
      err_flag   <= 1'b0;
    end else begin
      rd_pipe <= READ_LATENCY'({rd_pipe, (state == BURST) && rw});
      if (rd_pipe[READ_LATENCY-1]) rdata_hold <= mem_data_out;
      if (write_beat) wdata_hold <= cur_wdata;
      case (state)
        IDLE: if (handshake) begin
          g        <= pick;
          err_flag <= reject;
          // A rejected request leaves the memory-side registers untouched.
          if (reject) begin
            state <= DONE;
          end else begin
            base  <= sel_base;
            rw    <= sel_rw;
            beats <= sel_beats;
            beat  <= '0;
            state <= BURST;
          end
        end
        BURST: begin
          if (beat == beats - 5'd1) begin
            drain_cnt <= '0;
            state     <= rw ? DRAIN : DONE;
          end else begin
            beat <= beat + 5'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt == LAT_W'(READ_LATENCY - 1)) state <= DONE;
          else drain_cnt <= drain_cnt + LAT_W'(1);
        end
        DONE: begin
          err_flag <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_enable      = (state == BURST);
  assign mem_rw          = rw;
  assign mem_address     = base + ADDR_W'({beat, 2'b00});
  assign mem_access_size = ACCESS_1W;
  assign mem_data_in     = write_beat ? cur_wdata : wdata_hold;
  assign wdata_ack       = write_beat ? (2'b01 << g) : 2'b00;
  assign rdata_valid     = rd_pipe[READ_LATENCY-1] ? (2'b01 << g) : 2'b00;
  assign rdata           = rd_pipe[READ_LATENCY-1] ? mem_data_out : rdata_hold;
  assign done            = (state == DONE) ? (2'b01 << g) : 2'b00;
  assign err             = ((state == DONE) && err_flag) ? (2'b01 << g) : 2'b00;

endmodule
